// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run controller: req/done handshake, halt detect, watchdog, cycle count (optional RUN_CTRL_STEP_EN adds a step port)
module run_ctrl #(
  parameter logic [8:0] HALT_OP    = 9'h1FF,
  parameter int         MAX_CYCLES = 4096,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [8:0]       instruction,
`ifdef RUN_CTRL_STEP_EN
  input  logic             step,
`endif
  output logic             pc_init,
  output logic             pc_en,
  output logic             wr_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Count value of the last instruction allowed before the watchdog trips.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);

  state_t           state_q,   state_d;
  logic             pc_init_q, pc_init_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cycles_q,  cycles_d;

  logic step_w;
  logic is_halt;
  logic exec_w;

  // Step qualifier: without the step feature every RUN cycle is a step.
`ifdef RUN_CTRL_STEP_EN
  assign step_w = step;
`else
  assign step_w = 1'b1;
`endif

  assign is_halt = (instruction == HALT_OP);

  // An instruction executes only in RUN, with the host still requesting,
  // on a step cycle, and when it is not the halt word (halt is side-effect free).
  always_comb begin
    exec_w = 1'b0;
    if (state_q == S_RUN && req && step_w && !is_halt) begin
      exec_w = 1'b1;
    end
  end

  // Mealy strobes; gated by reset so an in-flight write is killed at once.
  always_comb begin
    pc_en = exec_w & reset;
    wr_en = exec_w & reset;
  end

  // Next-state and next-output decode; registered outputs follow the next state
  // so that none of them has a combinational path from req.
  always_comb begin
    state_d   = state_q;
    cycles_d  = cycles_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d   = S_INIT;
          cycles_d  = '0;
          timeout_d = 1'b0;
        end
      end

      S_INIT: begin
        state_d = req ? S_RUN : S_IDLE;
      end

      S_RUN: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (step_w) begin
          if (is_halt) begin
            state_d = S_DONE;
          end else begin
            if (cycles_q < MAX_CNT) begin
              cycles_d = cycles_q + CNT_W'(1);
            end
            if (cycles_q >= LAST_CNT) begin
              timeout_d = 1'b1;
              state_d   = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        if (!req) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    pc_init_d = (state_d == S_INIT);
    busy_d    = (state_d == S_INIT) || (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  // State and registered outputs; asynchronous clear returns everything to IDLE/0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_init_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_init_q <= pc_init_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
    end
  end

  assign pc_init = pc_init_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - directed scoreboard bench for run_ctrl
module tb_run_ctrl;

  localparam int MAXC = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [8:0]  instruction;
  logic        pc_init, pc_en, wr_en, busy, done, timeout;
  logic [15:0] cycles;
`ifdef RUN_CTRL_STEP_EN
  logic        step = 1'b0;
`endif

  logic [8:0]  rom [16];
  logic [3:0]  pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] cyc;
    logic        to;
    logic        ab;
  } exp_t;
  exp_t sb[$];

  int  n_init, n_en, n_wr, n_step;
  bit  seen;

  run_ctrl #(
    .HALT_OP   (9'h1FF),
    .MAX_CYCLES(MAXC),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .instruction(instruction),
`ifdef RUN_CTRL_STEP_EN
    .step       (step),
`endif
    .pc_init    (pc_init),
    .pc_en      (pc_en),
    .wr_en      (wr_en),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  // Program counter of the surrounding processor, driven by the DUT strobes.
  always @(posedge clk or negedge reset) begin
    if (!reset)       pc <= 4'd0;
    else if (pc_init) pc <= 4'd0;
    else if (pc_en)   pc <= pc + 4'd1;
  end

  assign instruction = rom[pc];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_rom(input int halt_at);
    for (int i = 0; i < 16; i++) begin
      rom[i] = (i == halt_at) ? 9'h1FF : 9'(i * 3 + 1);
    end
  endtask

  task automatic run_until_done(output int ni, output int ne, output int nw, output bit s);
    ni = 0; ne = 0; nw = 0; s = 1'b0;
    for (int i = 0; i < 60 && !s; i++) begin
      @(negedge clk);
      if (done) s = 1'b1;
      else begin
        ni += int'(pc_init);
        ne += int'(pc_en);
        nw += int'(wr_en);
      end
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_cycles"},  32'(cycles), 32'(e.cyc));
      chk({tag, "_timeout"}, 32'(timeout), 32'(e.to));
      chk({tag, "_done"},    32'(done), 32'(!e.ab));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: observed running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset and idle
    load_rom(5);
    repeat (3) @(negedge clk);
    chk("rst_outs", {26'd0, pc_init, pc_en, wr_en, busy, done, timeout}, 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", {26'd0, pc_init, pc_en, wr_en, busy, done, timeout}, 32'd0);
      chk("idle_cycles", 32'(cycles), 32'd0);
    end

    // Normal run: 5 instructions then halt
    sb.push_back('{16'd5, 1'b0, 1'b0});
    req = 1'b1;
    run_until_done(n_init, n_en, n_wr, seen);
    chk("norm_seen", 32'(seen), 32'd1);
    chk("norm_pc_init_n", 32'(n_init), 32'd1);
    chk("norm_pc_en_n", 32'(n_en), 32'd5);
    chk("norm_wr_en_n", 32'(n_wr), 32'd5);
    check_result("norm");
    chk("norm_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("norm_done_held", 32'(done), 32'd1);
    chk("norm_done_pc_en", 32'(pc_en), 32'd0);
    req = 1'b0;
    @(negedge clk);
    chk("norm_done_fall", 32'(done), 32'd0);
    chk("norm_cycles_held", 32'(cycles), 32'd5);

    // Watchdog: ROM never halts
    load_rom(-1);
    sb.push_back('{16'(MAXC), 1'b1, 1'b0});
    req = 1'b1;
    run_until_done(n_init, n_en, n_wr, seen);
    chk("wd_seen", 32'(seen), 32'd1);
    chk("wd_pc_en_n", 32'(n_en), 32'(MAXC));
    check_result("wd");
    req = 1'b0;
    @(negedge clk);

    // Abort on the third RUN cycle
    sb.push_back('{16'd2, 1'b0, 1'b1});
    req = 1'b1;
    @(negedge clk);
    chk("ab_pc_init", 32'(pc_init), 32'd1);
    chk("ab_init_clear", {30'd0, timeout, |cycles}, 32'd0);
    @(negedge clk);
    chk("ab_run1_wr", 32'(wr_en), 32'd1);
    @(negedge clk);
    chk("ab_run2_wr", 32'(wr_en), 32'd1);
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("ab_run3_wr", {30'd0, pc_en, wr_en}, 32'd0);
    @(negedge clk);
    chk("ab_idle_busy", 32'(busy), 32'd0);
    check_result("ab");
    repeat (3) @(negedge clk);
    chk("ab_no_done", 32'(done), 32'd0);

    // Mid-run asynchronous reset, then a fresh run
    load_rom(3);
    req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mr_running", 32'(pc_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mr_async", {29'd0, pc_en, wr_en, busy}, 32'd0);
    chk("mr_cycles", 32'(cycles), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_reinit", {30'd0, pc_init, busy}, 32'd3);
    sb.push_back('{16'd3, 1'b0, 1'b0});
    run_until_done(n_init, n_en, n_wr, seen);
    chk("mr_seen", 32'(seen), 32'd1);
    chk("mr_pc_en_n", 32'(n_en), 32'd3);
    check_result("mr");
    req = 1'b0;
    @(negedge clk);

`ifdef RUN_CTRL_STEP_EN
    // Step mode: three single-cycle pulses, then halt held until stepped
    load_rom(3);
    sb.push_back('{16'd3, 1'b0, 1'b0});
    req = 1'b1;
    @(negedge clk);
    n_step = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      step = (c % 5 == 0) && (c < 15);
      #1;
      n_step += int'(pc_en);
    end
    step = 1'b0;
    chk("st_pc_en_n", 32'(n_step), 32'd3);
    chk("st_cycles", 32'(cycles), 32'd3);
    repeat (3) @(negedge clk);
    chk("st_halt_wait", {30'd0, busy, done}, 32'd2);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check_result("st");
    req = 1'b0;
    @(negedge clk);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller for the 9-bit single-cycle processor. It converts the top-level `req`/`done` handshake into PC initialise and advance strobes and gates register-file and data-memory writes. It detects the halt opcode, enforces a cycle-limit watchdog and reports the executed cycle count. It sits between the top-level handshake pins and the PC, register-file write-enable and data-memory write-enable.

## Interface
- `HALT_OP`, 9'h1FF: instruction encoding that ends a run.
- `MAX_CYCLES`, 4096: watchdog limit, counted in executed RUN cycles; minimum 2.
- `CNT_W`, 16: width of `cycles`; must satisfy 2^CNT_W > MAX_CYCLES.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `req` input 1: level request from the host; high starts a run, low ends or aborts it.
- `instruction` input 9: current instruction-ROM output.
- `step` input 1: single-step enable. Present only with `RUN_CTRL_STEP_EN`.
- `pc_init` output 1: PC loads address 0 on the next edge.
- `pc_en` output 1: PC advances or branches on the next edge.
- `wr_en` output 1: AND-gate for the register-file `regWrite` and data-memory `DMwrite`.
- `busy` output 1: high in INIT or RUN.
- `done` output 1: run completed; high for the whole DONE state.
- `timeout` output 1: last run ended on the watchdog, not on `HALT_OP`.
- `cycles` output CNT_W: number of executed instructions in the current or last run.

## Operation
- States: IDLE, INIT, RUN, DONE. All state and outputs are registered except `pc_en` and `wr_en`, which are Mealy outputs decoded from state, `instruction` and `step`.
- IDLE:
  - Outputs are 0.
  - `req`=1 → INIT.
- INIT, exactly one cycle:
  - `pc_init`=1.
  - `cycles` and `timeout` are cleared.
  - → RUN. If `req`=0, → IDLE instead.
- RUN, in priority order:
  1. `req`=0: abort. `pc_en`=`wr_en`=0 in this cycle; → IDLE. `cycles` is held and `done` is never raised.
  2. `instruction`==`HALT_OP`: `pc_en`=`wr_en`=0, so the halt instruction has no side effects. → DONE, and `cycles` is not incremented.
  3. Otherwise:
     - `pc_en`=`wr_en`=1 and `cycles` increments.
     - If the pre-increment `cycles`==`MAX_CYCLES`-1, this instruction still executes, then `timeout`←1 and → DONE.
- DONE:
  - `done`=1; `pc_en`=`wr_en`=0.
  - `cycles` and `timeout` are held.
  - `req`=0 → IDLE. `req` held high stays in DONE; a new run requires `req` low for at least one cycle.
- `busy`=1 exactly when the state is INIT or RUN.
- `cycles` saturates at `MAX_CYCLES` and never wraps.
- Reset asserted at any time:
  - State → IDLE immediately (asynchronous), and every registered output is 0.
  - `pc_en` and `wr_en` drop combinationally.
  - An in-flight instruction's write is suppressed.

## Timing
- Start latency: `req` sampled high at edge k → `pc_init`=1 during cycle k..k+1. The PC is 0 and the first instruction executes in cycle k+1..k+2.
- Halt latency: `HALT_OP` presented in cycle n → `done`=1 from edge n+1.
- `done` fall: `req` sampled low at edge m → `done`=0 from edge m.
- Abort: `req` low in RUN → no write in that cycle; IDLE from the next edge.
- No combinational path from `req` to any output other than `pc_en`/`wr_en`.

## Configuration
- `RUN_CTRL_STEP_EN` defined:
  - The `step` port exists. In RUN, `pc_en`=`wr_en`=`step`.
  - `cycles` increments and the watchdog advances only on `step`=1 cycles.
  - `HALT_OP` is acted on only when `step`=1. With `step`=0 the state holds in RUN and abort still applies.
- `RUN_CTRL_STEP_EN` undefined: there is no `step` port, and behaviour is identical to `step` tied to 1.

## Test plan
- Reset/idle: hold `reset`=0, then release with `req`=0 → all outputs 0 and state IDLE for 10 cycles.
- Normal run: `req`=1; ROM gives 5 non-halt words, then 9'h1FF.
  - `pc_init` is high for one cycle, then `pc_en`=`wr_en`=1 for exactly 5 cycles.
  - Then `done`=1, `cycles`=5, `timeout`=0.
  - Drop `req` → `done`=0 on the next edge.
- Watchdog: `MAX_CYCLES`=8 with a ROM that never halts → `done`=1 after 8 RUN cycles, `cycles`=8, `timeout`=1.
- Abort: drop `req` on the 3rd RUN cycle → `wr_en`=0 in that cycle, state IDLE, `done` stays 0, `cycles`=2.
- Mid-run reset: assert `reset`=0 asynchronously between edges in RUN → `pc_en`, `wr_en` and `busy` fall before the next edge. After release with `req`=1, a fresh INIT occurs.
- Step mode (`RUN_CTRL_STEP_EN`): pulse `step` 3 times with gaps of 4 cycles → exactly 3 `pc_en` cycles and `cycles`=3. 9'h1FF with `step`=0 stays in RUN; with `step`=1 → DONE.
